// File: rtl/instr_fetch_buffer.sv
// Sequential instruction fetch stage: OBI request generation, in-order response FIFO, branch flush.
// Optional build macro FETCH_ERR_EN: per-entry bus error flag and fetch halt on error until branch.
module instr_fetch_buffer #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_enable_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o,
  output logic        fetch_err_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic [6:0]  instr_rdata_intg_i,
  input  logic        instr_err_i
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]            next_pc_q, next_pc_d, req_addr_q, req_addr_d;
  logic                   req_pending_q, req_pending_d, stale_q, stale_d;
  logic [CW-1:0]          outstanding_q, outstanding_d, discard_q, discard_d, count_q, count_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
  logic [DEPTH-1:0][31:0] fifo_data_q, fifo_data_d, fifo_addr_q, fifo_addr_d, aq_q, aq_d;

  logic          grant, drop_old, push, pop, issue, halt_block, unused_in;
  logic [CW:0]   inflight;
  logic [AW-1:0] head;

  assign grant    = req_pending_q & instr_gnt_i;
  assign drop_old = instr_rvalid_i & (discard_q != '0);
  assign push     = instr_rvalid_i & ~branch_i & ~drop_old;
  assign pop      = fetch_valid_o & fetch_ready_i & ~branch_i;
  // Discarded responses still occupy outstanding slots but will never land in the FIFO.
  assign inflight = {1'b0, count_q} + {1'b0, outstanding_q} - {1'b0, discard_q};
  assign issue    = ~branch_i & ~req_pending_q & fetch_enable_i & ~halt_block
                  & (inflight < {1'b0, DEPTH_C}) & (outstanding_q < DEPTH_C);

  // When empty, show the most recently popped (or flushed) entry so outputs hold.
  assign head          = (count_q == '0) ? rd_ptr_q - AW'(1) : rd_ptr_q;
  assign fetch_valid_o = (count_q != '0);
  assign fetch_rdata_o = fifo_data_q[head];
  assign fetch_addr_o  = fifo_addr_q[head];
  assign instr_req_o   = req_pending_q;
  assign instr_addr_o  = req_addr_q;

  always_comb begin
    next_pc_d     = next_pc_q;
    req_addr_d    = req_addr_q;
    req_pending_d = req_pending_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(instr_rvalid_i);
    discard_d     = discard_q;
    stale_d       = stale_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    aq_wr_d       = aq_wr_q;
    aq_rd_d       = aq_rd_q;
    aq_d          = aq_q;
    fifo_data_d   = fifo_data_q;
    fifo_addr_d   = fifo_addr_q;
    if (grant) begin
      req_pending_d = 1'b0;
      aq_d[aq_wr_q] = req_addr_q;
      aq_wr_d       = aq_wr_q + AW'(1);
    end
    if (instr_rvalid_i) aq_rd_d = aq_rd_q + AW'(1);
    if (issue) begin
      req_pending_d = 1'b1;
      req_addr_d    = next_pc_q;
      next_pc_d     = next_pc_q + 32'd4;
    end
    if (push) begin
      fifo_data_d[wr_ptr_q] = instr_rdata_i;
      fifo_addr_d[wr_ptr_q] = aq_q[aq_rd_q];
    end
    if (branch_i) begin
      next_pc_d = {branch_addr_i[31:2], 2'b00};
      count_d   = '0;
      rd_ptr_d  = (count_q != '0) ? rd_ptr_q + AW'(1) : rd_ptr_q;
      wr_ptr_d  = rd_ptr_d;
      // Everything granted and not yet returned is now stale, including a same-cycle grant.
      discard_d = outstanding_d;
      stale_d   = req_pending_q & ~instr_gnt_i;
    end else begin
      count_d   = count_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      discard_d = discard_q - CW'(drop_old) + CW'(grant & stale_q);
      if (grant) stale_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      next_pc_q     <= BOOT_ADDR;
      req_addr_q    <= BOOT_ADDR;
      req_pending_q <= 1'b0;
      stale_q       <= 1'b0;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      aq_wr_q       <= '0;
      aq_rd_q       <= '0;
      aq_q          <= '0;
      fifo_data_q   <= '0;
      fifo_addr_q   <= '0;
    end else begin
      next_pc_q     <= next_pc_d;
      req_addr_q    <= req_addr_d;
      req_pending_q <= req_pending_d;
      stale_q       <= stale_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      aq_wr_q       <= aq_wr_d;
      aq_rd_q       <= aq_rd_d;
      aq_q          <= aq_d;
      fifo_data_q   <= fifo_data_d;
      fifo_addr_q   <= fifo_addr_d;
    end
  end

`ifdef FETCH_ERR_EN
  logic [DEPTH-1:0] fifo_err_q, fifo_err_d;
  logic             halted_q, halted_d;

  // An error response stops issue in its own cycle as well, not just from the next one.
  assign halt_block  = halted_q | (push & instr_err_i);
  assign fetch_err_o = fifo_err_q[head];
  assign unused_in   = ^{instr_rdata_intg_i, branch_addr_i[1:0]};

  always_comb begin
    fifo_err_d = fifo_err_q;
    halted_d   = halted_q;
    if (push) fifo_err_d[wr_ptr_q] = instr_err_i;
    if (branch_i)                 halted_d = 1'b0;
    else if (push && instr_err_i) halted_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_err_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      fifo_err_q <= fifo_err_d;
      halted_q   <= halted_d;
    end
  end
`else
  assign halt_block  = 1'b0;
  assign fetch_err_o = 1'b0;
  assign unused_in   = ^{instr_rdata_intg_i, branch_addr_i[1:0], instr_err_i};
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: cycle tables, directed corner sequences and a random run
// checked against a sequential-stream reference model with an in-order RAM responder.
module tb_instr_fetch_buffer;
  localparam int DEPTH = 2;
  localparam logic [31:0] BOOT = 32'h0000_0000;
`ifdef FETCH_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst_n;
  logic        fetch_enable, branch, fetch_ready, gnt, rvalid, rerr;
  logic [31:0] baddr, rdata;
  logic [6:0]  intg;
  logic        fetch_valid_o, fetch_err_o, instr_req_o;
  logic [31:0] fetch_rdata_o, fetch_addr_o, instr_addr_o;

  instr_fetch_buffer #(.BOOT_ADDR(BOOT), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .fetch_enable_i(fetch_enable), .branch_i(branch),
    .branch_addr_i(baddr), .fetch_valid_o(fetch_valid_o), .fetch_ready_i(fetch_ready),
    .fetch_rdata_o(fetch_rdata_o), .fetch_addr_o(fetch_addr_o), .fetch_err_o(fetch_err_o),
    .instr_req_o(instr_req_o), .instr_gnt_i(gnt), .instr_addr_o(instr_addr_o),
    .instr_rvalid_i(rvalid), .instr_rdata_i(rdata), .instr_rdata_intg_i(intg),
    .instr_err_i(rerr));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } resp_t;
  typedef struct {
    bit do_rst; bit g; bit r;
    bit exp_req; logic [31:0] exp_addr; bit exp_vld; logic [31:0] exp_faddr;
  } vec_t;

  resp_t       rq[$];
  vec_t        tv[$];
  int          n_vec = 0, n_err = 0, n_pop = 0, cyc = 0, lat = 1;
  logic [31:0] exp_pc, err_addr, prev_addr;
  bit          prev_req, prev_gnt, ok;

  function automatic logic [31:0] ram(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive this cycle's RAM response, then move to the sampling point.
  task automatic pre();
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      rvalid = 1'b1;
      rdata  = ram(rq[0].addr);
      rerr   = (rq[0].addr == err_addr);
      void'(rq.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
      rerr   = 1'($urandom);
    end
    @(negedge clk);
  endtask

  // Reference model: deliveries form a contiguous word stream restarted by each branch.
  task automatic model();
    if (prev_req && !prev_gnt) begin
      check("req_hold", 32'(instr_req_o), 32'd1);
      check("addr_hold", instr_addr_o, prev_addr);
    end
    if (fetch_valid_o && fetch_ready && !branch) begin
      check("pop_addr", fetch_addr_o, exp_pc);
      check("pop_data", fetch_rdata_o, ram(exp_pc));
      check("pop_err", 32'(fetch_err_o), 32'(ERR_EN && exp_pc == err_addr));
      exp_pc += 32'd4;
      n_pop++;
    end
    if (branch) exp_pc = baddr & ~32'h3;
  endtask

  task automatic post();
    int due;
    if (instr_req_o && gnt) begin
      due = cyc + lat;
      if (rq.size() > 0 && rq[$].due >= due) due = rq[$].due + 1;
      rq.push_back('{instr_addr_o, due});
      check("inflight_cap", 32'(rq.size() <= DEPTH), 32'd1);
    end
    prev_req = instr_req_o; prev_gnt = gnt; prev_addr = instr_addr_o;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic tick();
    pre(); model(); post();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fetch_enable = 1'b0; gnt = 1'b0; fetch_ready = 1'b0; branch = 1'b0;
    baddr = '0; rvalid = 1'b0; rerr = 1'b0; rdata = '0; intg = '0;
    rq.delete();
    #1;
    check("rst_async_req", 32'(instr_req_o), 32'd0);
    check("rst_async_vld", 32'(fetch_valid_o), 32'd0);
    @(negedge clk);
    check("rst_addr", instr_addr_o, BOOT);
    check("rst_rdata", fetch_rdata_o, 32'd0);
    check("rst_faddr", fetch_addr_o, 32'd0);
    check("rst_err", 32'(fetch_err_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; cyc = 0; exp_pc = BOOT; prev_req = 1'b0; err_addr = '1;
  endtask

  // Leaves the bench at the sampling point of the first cycle with fetch_valid_o high.
  task automatic wait_valid(input int bound, output bit found);
    int n = 0;
    pre();
    while (!fetch_valid_o && n < bound) begin
      model(); post(); pre(); n++;
    end
    found = fetch_valid_o;
    if (!found) begin
      n_vec++; n_err++;
      $display("FAIL wait_valid: fetch_valid_o still %b after %0d cycles", fetch_valid_o, bound);
    end
  endtask

  task automatic expect_stream(input logic [31:0] start, input int n);
    bit f;
    for (int k = 0; k < n; k++) begin
      wait_valid(40, f);
      check($sformatf("stream_addr_%0d", k), fetch_addr_o, start + 32'(4 * k));
      check($sformatf("stream_data_%0d", k), fetch_rdata_o, ram(start + 32'(4 * k)));
      model(); post();
    end
  endtask

  task automatic add(input bit rs, input bit g, input bit r, input bit req,
                     input logic [31:0] a, input bit v, input logic [31:0] fa);
    tv.push_back('{rs, g, r, req, a, v, fa});
  endtask

  task automatic flush_test(input int l, input logic [31:0] tgt);
    bit f;
    do_reset();
    lat = l; gnt = 1'b1; fetch_ready = 1'b0; fetch_enable = 1'b1;
    repeat (4) tick();
    branch = 1'b1; baddr = tgt;
    pre();
    check($sformatf("flush%0d_pre_vld", l), 32'(fetch_valid_o), 32'd1);
    check($sformatf("flush%0d_pre_faddr", l), fetch_addr_o, 32'h0);
    model(); post();
    branch = 1'b0;
    pre();
    check($sformatf("flush%0d_post_vld", l), 32'(fetch_valid_o), 32'd0);
    model(); post();
    fetch_ready = 1'b1;
    wait_valid(40, f);
    check($sformatf("flush%0d_first", l), fetch_addr_o, tgt);
    model(); post();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, %0d vectors so far", n_vec);
    $fatal(1);
  end

  initial begin
    // Streaming, gnt=1 and ready=1, rvalid one cycle after grant.
    add(1,1,1, 0,32'h0, 0,32'h0); add(0,1,1, 1,32'h0, 0,32'h0);
    add(0,1,1, 0,32'h0, 0,32'h0); add(0,1,1, 1,32'h4, 1,32'h0);
    add(0,1,1, 0,32'h4, 0,32'h0); add(0,1,1, 1,32'h8, 1,32'h4);
    add(0,1,1, 0,32'h8, 0,32'h4); add(0,1,1, 1,32'hC, 1,32'h8);
    add(0,1,1, 0,32'hC, 0,32'h8); add(0,1,1, 1,32'h10,1,32'hC);
    // Backpressure: ready=0 fills both entries and stops issue; ready from cycle 6.
    add(1,1,0, 0,32'h0, 0,32'h0); add(0,1,0, 1,32'h0, 0,32'h0);
    add(0,1,0, 0,32'h0, 0,32'h0); add(0,1,0, 1,32'h4, 1,32'h0);
    add(0,1,0, 0,32'h4, 1,32'h0); add(0,1,0, 0,32'h4, 1,32'h0);
    add(0,1,1, 0,32'h4, 1,32'h0); add(0,1,1, 0,32'h4, 1,32'h4);
    add(0,1,1, 1,32'h8, 0,32'h4); add(0,1,1, 0,32'h8, 0,32'h4);
    add(0,1,1, 1,32'hC, 1,32'h8);

    foreach (tv[i]) begin
      if (tv[i].do_rst) do_reset();
      lat = 1; fetch_enable = 1'b1; branch = 1'b0;
      gnt = tv[i].g; fetch_ready = tv[i].r;
      pre();
      check($sformatf("tbl%0d_req", i), 32'(instr_req_o), 32'(tv[i].exp_req));
      check($sformatf("tbl%0d_addr", i), instr_addr_o, tv[i].exp_addr);
      check($sformatf("tbl%0d_vld", i), 32'(fetch_valid_o), 32'(tv[i].exp_vld));
      check($sformatf("tbl%0d_faddr", i), fetch_addr_o, tv[i].exp_faddr);
      model(); post();
    end

    // Grant stall with a branch while the request is still ungranted.
    do_reset();
    lat = 1; gnt = 1'b0; fetch_ready = 1'b1; fetch_enable = 1'b1;
    tick();
    pre(); check("stall_c1_req", 32'(instr_req_o), 32'd1); model(); post();
    branch = 1'b1; baddr = 32'h0000_0103;
    pre(); check("stall_c2_addr", instr_addr_o, 32'h0); model(); post();
    branch = 1'b0;
    pre(); check("stall_c3_addr", instr_addr_o, 32'h0); model(); post();
    gnt = 1'b1;
    pre(); check("stall_c4_addr", instr_addr_o, 32'h0); model(); post();
    tick();
    pre();
    check("stall_new_req", 32'(instr_req_o), 32'd1);
    check("stall_new_addr", instr_addr_o, 32'h100);
    check("stall_dropped", 32'(fetch_valid_o), 32'd0);
    model(); post();
    expect_stream(32'h100, 2);

    // Flush with the in-flight response arriving in the branch cycle, then one cycle later.
    flush_test(1, 32'h200);
    flush_test(2, 32'h300);

    // Address wrap past the top of the address space.
    do_reset();
    lat = 1; gnt = 1'b1; fetch_ready = 1'b1; fetch_enable = 1'b1;
    branch = 1'b1; baddr = 32'hFFFF_FFFA;
    tick();
    branch = 1'b0;
    expect_stream(32'hFFFF_FFF8, 3);

`ifdef FETCH_ERR_EN
    do_reset();
    lat = 1; gnt = 1'b1; fetch_ready = 1'b1; fetch_enable = 1'b1; err_addr = 32'h8;
    expect_stream(32'h0, 2);
    wait_valid(40, ok);
    check("err_addr", fetch_addr_o, 32'h8);
    check("err_flag", 32'(fetch_err_o), 32'd1);
    model(); post();
    for (int k = 0; k < 6; k++) begin
      pre(); check($sformatf("halt_noreq_%0d", k), 32'(instr_req_o), 32'd0); model(); post();
    end
    err_addr = '1; branch = 1'b1; baddr = 32'h0;
    tick();
    branch = 1'b0;
    expect_stream(32'h0, 2);
`endif

    // Random traffic against the stream model.
    do_reset();
    n_pop = 0;
    for (int k = 0; k < 3000; k++) begin
      fetch_enable = ($urandom_range(0, 9) != 0);
      gnt          = ($urandom_range(0, 3) != 0);
      fetch_ready  = ($urandom_range(0, 2) != 0);
      lat          = int'($urandom_range(1, 3));
      branch       = ($urandom_range(0, 19) == 0);
      baddr        = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      tick();
    end
    check("rand_progress", 32'(n_pop > 100), 32'd1);

    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
